ssd_scan_ctl: RTL
=================

SSD_SCAN_CTL -- requirements
Module: ssd_scan_ctl

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, clock cycles each digit is driven (legal range 2..2^20).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port in_val  input  4  unsigned counter value to display (0..15), sampled only at frame boundaries.
REQ-005 SHALL have port ssd_ctl  output  4  digit enables, active-low, one-hot-zero (exactly one bit low).
REQ-006 SHALL have port segs  output  8  segment drive {a,b,c,d,e,f,g,dp}, active-low, dp always 1.
REQ-007 SHALL have port frame_done  output  1  one-cycle pulse marking start of a new scan frame.

Function
REQ-008 SHALL keep a refresh counter of ceil(log2(REFRESH_DIV)) bits counting 0..REFRESH_DIV-1 then wrapping to 0; "tick" = counter equal to REFRESH_DIV-1.
REQ-009 SHALL implement FSM with states DIG0->DIG1->DIG2->DIG3->DIG0, advancing only on the edge where tick is true; otherwise holding.
REQ-010 SHALL drive ssd_ctl DIG0=1110, DIG1=1101, DIG2=1011, DIG3=0111.
REQ-011 SHALL register ssd_ctl, segs and frame_done, updating them on the same edge as the state advance, derived from next state.
REQ-012 SHALL capture in_val into a 4-bit latch on the DIG3->DIG0 edge; segs for DIG0 on that edge SHALL use the newly captured value.
REQ-013 SHALL hold the latched value for the whole frame; in_val changes mid-frame SHALL NOT alter displayed digits.
REQ-014 SHALL compute ones = latched mod 10 and tens = latched / 10 (tens is 0 or 1).
REQ-015 SHALL show ones on DIG0, tens on DIG1, blank (segs=11111111) on DIG2 and DIG3.
REQ-016 SHALL encode digits 0..9 as 00000011, 10011111, 00100101, 00001101, 10011001, 01001001, 01000001, 00011111, 00000001, 00001001.
REQ-017 SHALL pulse frame_done high for exactly one cycle on each DIG3->DIG0 edge; low otherwise.
REQ-018 SHALL give each digit exactly REFRESH_DIV cycles and a full frame exactly 4*REFRESH_DIV cycles.

Reset
REQ-019 SHALL, while rst=1 and independently of clk, force state DIG0, refresh counter 0, latch 0, ssd_ctl=1110, segs=00000011, frame_done=0.
REQ-020 SHALL, on rst asserted mid-frame, abandon the frame with no frame_done pulse; first tick after release is REFRESH_DIV edges later.

Configuration
REQ-021 SHALL support macro SSD_LEADING_ZERO_BLANK_EN.
REQ-022 SHALL, with SSD_LEADING_ZERO_BLANK_EN defined, drive DIG1 segs=11111111 when tens=0.
REQ-023 SHALL, without SSD_LEADING_ZERO_BLANK_EN, drive DIG1 with the code for 0 (00000011) when tens=0; all other behaviour identical.

Verification (REFRESH_DIV=4)
REQ-024 SHALL check: rst=1 asynchronously mid-cycle -> ssd_ctl=1110, segs=00000011, frame_done=0 immediately.
REQ-025 SHALL check: release rst, in_val=13 held -> DIG1 at edge 4; frame_done high only after edge 16; DIG0 segs=00001101; DIG1 segs=10011111; DIG2/DIG3 segs=11111111.
REQ-026 SHALL check: in_val 13 then 7 at DIG1 of frame 2 -> frame 2 keeps showing 3/1; frame 3 shows 00011111 on DIG0.
REQ-027 SHALL check: in_val=5 -> DIG1 segs=11111111 with the macro, 00000011 without it.
REQ-028 SHALL check: in_val=15 -> DIG0 segs=01001001, DIG1 segs=10011111; rst pulse during DIG2 -> DIG0 restored, no frame_done.
REQ-029 SHALL check: over 100 frames, frame_done period is exactly 16 cycles and ssd_ctl always has exactly one 0 bit.

Source files
------------

// File: rtl/ssd_scan_ctl.sv
// ssd_scan_ctl: four-digit, multiplexed seven-segment scan controller.
//
// Shows a 4-bit value (0..15) as decimal digits. The ones digit is on DIG0,
// the tens digit is on DIG1, and DIG2/DIG3 are blank. Each digit is driven
// for REFRESH_DIV cycles. The value is sampled once per frame, on the
// DIG3->DIG0 transition.
//
// Parameters:
//   REFRESH_DIV  clock cycles per digit (2 .. 2^20)
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous, active-high reset
//   in_val      value to display, sampled at frame boundaries
//   ssd_ctl     digit enables, active-low, exactly one bit low
//   segs        {a,b,c,d,e,f,g,dp}, active-low, dp always 1
//   frame_done  one-cycle pulse at the start of each new frame
// Build option:
//   SSD_LEADING_ZERO_BLANK_EN  blanks DIG1 when the tens digit is 0
module ssd_scan_ctl #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] in_val,
  output logic [3:0] ssd_ctl,
  output logic [7:0] segs,
  output logic       frame_done
);

  localparam int unsigned CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [7:0] BLANK = 8'b1111_1111;

  typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [3:0]    latch, latch_nx;
  logic [3:0]    ones, tens;
  logic          tick, wrap;
  logic [3:0]    ssd_nx;
  logic [7:0]    segs_nx;

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 8'b0000_0011;
      4'd1:    seg_code = 8'b1001_1111;
      4'd2:    seg_code = 8'b0010_0101;
      4'd3:    seg_code = 8'b0000_1101;
      4'd4:    seg_code = 8'b1001_1001;
      4'd5:    seg_code = 8'b0100_1001;
      4'd6:    seg_code = 8'b0100_0001;
      4'd7:    seg_code = 8'b0001_1111;
      4'd8:    seg_code = 8'b0000_0001;
      4'd9:    seg_code = 8'b0000_1001;
      default: seg_code = BLANK;
    endcase
  endfunction

  // Outputs are decoded from the next state and the next latch value.
  // This way, DIG0 shows the value captured on the same edge.
  always_comb begin
    tick     = (cnt == CNT_MAX);
    wrap     = tick && (state == DIG3);
    state_nx = state;
    if (tick) begin
      case (state)
        DIG0:    state_nx = DIG1;
        DIG1:    state_nx = DIG2;
        DIG2:    state_nx = DIG3;
        default: state_nx = DIG0;
      endcase
    end
    latch_nx = wrap ? in_val : latch;
    tens     = (latch_nx >= 4'd10) ? 4'd1 : 4'd0;
    ones     = (latch_nx >= 4'd10) ? latch_nx - 4'd10 : latch_nx;
    ssd_nx   = 4'b1110;
    segs_nx  = BLANK;
    case (state_nx)
      DIG0: begin
        ssd_nx  = 4'b1110;
        segs_nx = seg_code(ones);
      end
      DIG1: begin
        ssd_nx  = 4'b1101;
`ifdef SSD_LEADING_ZERO_BLANK_EN
        segs_nx = (tens == 4'd0) ? BLANK : seg_code(tens);
`else
        segs_nx = seg_code(tens);
`endif
      end
      DIG2:    ssd_nx = 4'b1011;
      default: ssd_nx = 4'b0111;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= DIG0;
      cnt        <= '0;
      latch      <= '0;
      ssd_ctl    <= 4'b1110;
      segs       <= 8'b0000_0011;
      frame_done <= 1'b0;
    end else begin
      cnt        <= tick ? '0 : cnt + 1'b1;
      state      <= state_nx;
      latch      <= latch_nx;
      ssd_ctl    <= ssd_nx;
      segs       <= segs_nx;
      frame_done <= wrap;
    end
  end

endmodule
